// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: holds the PC and fetches words over a req/ack handshake.
// Presents each word until commit. Define FETCH_TIMEOUT_EN to enable the fetch timeout.
module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC       = 32'h0000_0000,
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic        clk_i,
  input  logic        rst_i,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_ack_i,
  input  logic [31:0] imem_rdata_i,
  output logic [31:0] instr_o,
  output logic        instr_valid_o,
  output logic [31:0] pc_o,
  output logic [31:0] pc_plus4_o,
  input  logic        commit_i,
  input  logic [1:0]  jump_i,
  input  logic        branch_i,
  input  logic [1:0]  branch_type_i,
  input  logic        zero_i,
  input  logic        sign_i,
  input  logic [31:0] jr_addr_i,
  output logic        fetch_err_o
);

  if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be in 2..255");
  end

  typedef enum logic [1:0] {StRst, StReq, StIssue, StHalt} state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic        req_q, req_d;
  logic        err_q, err_d;
  logic        timeout;
  logic [31:0] p4, br_off, next_pc;
  logic        br_cond;

`ifdef FETCH_TIMEOUT_EN
  logic [7:0] wait_q, wait_d;

  // Last allowed REQ cycle without ack; an ack in that same cycle still wins.
  assign timeout = (state_q == StReq) && !imem_ack_i && (wait_q == 8'(TIMEOUT_CYCLES - 1));

  always_comb begin
    wait_d = 8'd0;
    if (state_q == StReq && !imem_ack_i) wait_d = wait_q + 8'd1;
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) wait_q <= 8'd0;
    else        wait_q <= wait_d;
  end
`else
  assign timeout = 1'b0;
`endif

  // Next-PC selection, evaluated from the held instruction at commit.
  assign p4     = pc_q + 32'd4;
  assign br_off = {{14{instr_q[15]}}, instr_q[15:0], 2'b00};

  always_comb begin
    br_cond = 1'b0;
    unique case (branch_type_i)
      2'b00: br_cond = zero_i;
      2'b01: br_cond = !zero_i;
      2'b10: br_cond = zero_i | sign_i;
      2'b11: br_cond = !zero_i & !sign_i;
      default: br_cond = 1'b0;
    endcase
  end

  always_comb begin
    next_pc = p4;
    unique case (jump_i)
      2'b00:   next_pc = {p4[31:28], instr_q[25:0], 2'b00};
      2'b10:   next_pc = jr_addr_i & ~32'h3;
      default: next_pc = (branch_i && br_cond) ? p4 + br_off : p4;
    endcase
  end

  // State register.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= StRst;
      pc_q    <= RESET_PC;
      instr_q <= 32'h0;
      req_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      req_q   <= req_d;
      err_q   <= err_d;
    end
  end

  // Next-state and datapath updates.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    err_d   = err_q | timeout;
    unique case (state_q)
      StRst: state_d = StReq;
      StReq: begin
        if (imem_ack_i) begin
          instr_d = imem_rdata_i;
          state_d = StIssue;
        end else if (timeout) begin
          state_d = StHalt;
        end
      end
      StIssue: begin
        if (commit_i) begin
          pc_d    = next_pc;
          state_d = StReq;
        end
      end
      StHalt: state_d = StHalt;
      default: state_d = StRst;
    endcase
    req_d = (state_d == StReq);
  end

  // Outputs.
  always_comb begin
    imem_req_o    = req_q;
    imem_addr_o   = pc_q;
    instr_o       = instr_q;
    instr_valid_o = (state_q == StIssue);
    pc_o          = pc_q;
    pc_plus4_o    = p4;
    fetch_err_o   = err_q;
  end

endmodule
